// File: rtl/fnd_pkg.sv
// Shared definitions for the 4-digit 7-segment scan driver: BCD digit type,
// active-low segment patterns ({dp,g,f,e,d,c,b,a}), blank pattern and clamp limit.
package fnd_pkg;

   localparam int unsigned BIN_W   = 14;
   localparam int unsigned BCD_W   = 16;
   localparam int unsigned DIGIT_W = 4;

   typedef logic [DIGIT_W-1:0] bcd_t;

   localparam logic [BIN_W-1:0] CLAMP_MAX = 14'd9999;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_0     = 8'hC0;
   localparam logic [7:0] SEG_1     = 8'hF9;
   localparam logic [7:0] SEG_2     = 8'hA4;
   localparam logic [7:0] SEG_3     = 8'hB0;
   localparam logic [7:0] SEG_4     = 8'h99;
   localparam logic [7:0] SEG_5     = 8'h92;
   localparam logic [7:0] SEG_6     = 8'h82;
   localparam logic [7:0] SEG_7     = 8'hF8;
   localparam logic [7:0] SEG_8     = 8'h80;
   localparam logic [7:0] SEG_9     = 8'h90;

   // Digit to segment pattern, dp off; non-decimal codes are blank
   function automatic logic [7:0] seg_decode(input bcd_t d);
      logic [7:0] p;
      case (d)
         4'd0:    p = SEG_0;
         4'd1:    p = SEG_1;
         4'd2:    p = SEG_2;
         4'd3:    p = SEG_3;
         4'd4:    p = SEG_4;
         4'd5:    p = SEG_5;
         4'd6:    p = SEG_6;
         4'd7:    p = SEG_7;
         4'd8:    p = SEG_8;
         4'd9:    p = SEG_9;
         default: p = SEG_BLANK;
      endcase
      return p;
   endfunction

   // Saturate a binary value to the largest 4-digit decimal number
   function automatic logic [BIN_W-1:0] clamp_bin(input logic [BIN_W-1:0] b);
      return (b > CLAMP_MAX) ? CLAMP_MAX : b;
   endfunction

endpackage

// File: rtl/fnd_scan_driver_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// start is accepted only when idle; done pulses one cycle after the last shift.
module bin2bcd_seq
   import fnd_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [BIN_W-1:0] bin,
   output logic             busy,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   localparam int unsigned SR_W  = BCD_W + BIN_W;
   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BIN_W - 1);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state;
   state_t           state_next;
   logic             busy_next;
   logic             done_next;
   logic [CNT_W-1:0] cnt;
   logic [SR_W-1:0]  sr;

   // One double-dabble iteration: adjust every BCD nibble >= 5, then shift left
   function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] v);
      logic [SR_W-1:0] a;
      a = v;
      for (int i = 0; i < 4; i++) begin
         if (a[BIN_W + 4*i +: 4] >= 4'd5)
            a[BIN_W + 4*i +: 4] = a[BIN_W + 4*i +: 4] + 4'd3;
      end
      return {a[SR_W-2:0], 1'b0};
   endfunction

   // State register with registered handshake flags
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= busy_next;
         done  <= done_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_SHIFT;
         S_SHIFT: if (cnt == LAST_SHIFT) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Handshake flags derived from the upcoming state
   always_comb begin
      busy_next = 1'b0;
      done_next = 1'b0;
      busy_next = (state_next != S_IDLE);
      done_next = (state_next == S_DONE);
   end

   // Shift register and shift counter
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         sr  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  sr  <= {BCD_W'(0), bin};
                  cnt <= '0;
               end
            end
            S_SHIFT: begin
               sr  <= dabble_step(sr);
               cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign bcd = sr[SR_W-1:BIN_W];

endmodule

// File: rtl/fnd_scan_driver.sv
// 4-digit multiplexed 7-segment driver: prescaled digit scan, per-frame input
// capture with clamp to 9999, sequential BCD conversion, glitch-free commit.
// Optional leading-zero blanking: define FND_LEADING_ZERO_BLANK_EN.
module fnd_scan_driver
   import fnd_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100_000,
   parameter int          DP_POS   = 1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] fnd_in_data,
   output logic [3:0]  fnd_digit,
   output logic [7:0]  fnd_data
);

   localparam int unsigned PRE_W = $clog2(SCAN_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   logic [PRE_W-1:0] pre;
   logic             tick;
   logic [1:0]       idx;
   logic [1:0]       idx_next;
   logic             frame_start;
   logic [BIN_W-1:0] cap;
   logic [BCD_W-1:0] disp;
   logic [BCD_W-1:0] show_val;
   logic             cvt_start;
   logic             cvt_busy;
   logic             cvt_done;
   logic [BIN_W-1:0] cvt_bin;
   logic [BCD_W-1:0] cvt_bcd;

   // Segment pattern for one slot, including blanking and decimal point
   function automatic logic [7:0] slot_pattern(input logic [BCD_W-1:0] val,
                                               input logic [1:0] slot);
      logic [7:0] p;
      logic       blank;
      p     = seg_decode(val[{slot, 2'b00} +: DIGIT_W]);
      blank = 1'b0;
`ifdef FND_LEADING_ZERO_BLANK_EN
      case (slot)
         2'd3:    blank = (val[15:12] == 4'd0);
         2'd2:    blank = (val[15:8]  == 8'd0);
         2'd1:    blank = (val[15:4]  == 12'd0);
         default: blank = 1'b0;
      endcase
      if (int'(slot) <= DP_POS) blank = 1'b0;
`endif
      if (blank) p = SEG_BLANK;
      if (int'(slot) == DP_POS) p[7] = 1'b0;
      return p;
   endfunction

   // Scan timing, frame start and converter input selection
   always_comb begin
      tick        = (pre == PRE_LAST);
      idx_next    = idx + 2'd1;
      frame_start = tick && (idx == 2'd3);
      cvt_start   = frame_start && !cvt_busy;
      cvt_bin     = clamp_bin(frame_start ? fnd_in_data : cap);
      show_val    = cvt_done ? cvt_bcd : disp;
   end

   // Prescaler: one tick every SCAN_DIV clocks
   always_ff @(posedge clk) begin
      if (reset)     pre <= '0;
      else if (tick) pre <= '0;
      else           pre <= pre + PRE_W'(1);
   end

   // Scan index; reset to 3 so the first tick starts a frame
   always_ff @(posedge clk) begin
      if (reset)     idx <= 2'd3;
      else if (tick) idx <= idx_next;
   end

   // Input capture at frame start
   always_ff @(posedge clk) begin
      if (reset)            cap <= '0;
      else if (frame_start) cap <= fnd_in_data;
   end

   // Display register, updated only with a finished conversion
   always_ff @(posedge clk) begin
      if (reset)         disp <= '0;
      else if (cvt_done) disp <= cvt_bcd;
   end

   // Registered anode and segment outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         fnd_digit <= 4'b1111;
         fnd_data  <= SEG_BLANK;
      end else if (tick) begin
         fnd_digit <= ~(4'b0001 << idx_next);
         fnd_data  <= slot_pattern(show_val, idx_next);
      end else if (cvt_done) begin
         fnd_data  <= slot_pattern(cvt_bcd, idx);
      end
   end

   bin2bcd_seq u_bin2bcd (
      .clk   (clk),
      .reset (reset),
      .start (cvt_start),
      .bin   (cvt_bin),
      .busy  (cvt_busy),
      .done  (cvt_done),
      .bcd   (cvt_bcd)
   );

endmodule

// File: doc/fnd_scan_driver.md
FND_SCAN_DRIVER -- requirements
Module: fnd_scan_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100_000, meaning clocks per digit slot (1 kHz digit rate at 100 MHz); legal range >= 32.
REQ-002 SHALL have parameter DP_POS, default 1, meaning the digit index (0 = units) whose decimal point is lit; a value of 4 or more means no point.
REQ-003 SHALL have port clk, input, 1 bit: system clock.
REQ-004 SHALL have port reset, input, 1 bit: reset. One clock; reset is synchronous and active-high.
REQ-005 SHALL have port fnd_in_data, input, 14 bits: binary value to display.
REQ-006 SHALL have port fnd_digit, output, 4 bits: active-low one-hot anode select; bit 0 is the units digit.
REQ-007 SHALL have port fnd_data, output, 8 bits: active-low segments ordered {dp,g,f,e,d,c,b,a}.

Function
REQ-008 SHALL run a prescaler counting 0..SCAN_DIV-1 and emit a 1-cycle scan tick at SCAN_DIV-1.
REQ-009 SHALL advance a 2-bit scan index on each tick: 0->1->2->3->0.
REQ-010 SHALL register fnd_digit and fnd_data, so both change exactly 1 cycle after the tick and never change between ticks except on a display commit.
REQ-011 SHALL sample fnd_in_data into a capture register on the tick where the index wraps 3->0 (frame start), and start one conversion in the same cycle.
REQ-012 SHALL clamp captured values above 9999 to 9999 before conversion.
REQ-013 SHALL convert binary to 4-digit BCD sequentially with shift-add-3 (double dabble): 14 shift cycles; done pulses 1 cycle after the last shift; total latency from start to done is 15 cycles.
REQ-014 SHALL copy the BCD result into the display register on the done pulse only; the digits being shown come from the display register, so a frame never shows a half-updated value.
REQ-015 SHALL ignore a start while a conversion is busy; this cannot occur for legal SCAN_DIV.
REQ-016 SHALL decode BCD 0-9 to standard 7-segment patterns; codes 10-15 SHALL display all segments off.
REQ-017 SHALL drive dp low (lit) only when the scan index equals DP_POS.
REQ-018 SHALL treat fnd_in_data changes outside the capture cycle as invisible until the next frame start.

Reset
REQ-019 SHALL, on reset, set fnd_digit = 4'b1111, fnd_data = 8'hFF, prescaler = 0, scan index = 3 (the first tick wraps to 0 and triggers a capture), capture and display registers = 0, and converter = idle.
REQ-020 SHALL abort an in-flight conversion on reset, with no done pulse and no commit.

Configuration
REQ-021 SHALL implement leading-zero blanking when macro FND_LEADING_ZERO_BLANK_EN is defined: a digit above max(DP_POS,0) SHALL be blank (all segments off) when it and every higher digit are zero; the units digit and the digit at DP_POS are never blanked.
REQ-022 SHALL show all four digits, including leading zeros, when FND_LEADING_ZERO_BLANK_EN is undefined.

Structure
REQ-023 SHALL place the 7-segment pattern constants, the blank pattern (8'hFF), the clamp limit 9999 and the BCD digit type in shared package fnd_pkg.
REQ-024 SHALL contain exactly one sub-module, bin2bcd_seq, with start/busy/done handshake, 14-bit binary in and 16-bit BCD out; prescaler, scan, decode and blanking stay in the top module.

Verification (SCAN_DIV=32, DP_POS=1 unless stated)
REQ-025 SHALL verify: reset is released with fnd_in_data=1234 -> outputs are 4'b1111/8'hFF until the first tick; a commit follows 15 cycles after that tick; the scan then shows 4, 3 (dp lit), 2, 1 with fnd_digit 1110, 1101, 1011, 0111.
REQ-026 SHALL verify: fnd_in_data=16383 -> displays 9999.
REQ-027 SHALL verify: fnd_in_data is changed from 1234 to 5678 mid-frame -> the remaining slots of the frame still show 1234 digits, and 5678 appears only after the next frame start plus 15 cycles.
REQ-028 SHALL verify: fnd_in_data=7 with the macro defined -> digits 3 and 2 show 8'hFF, digit 1 shows "0." and digit 0 shows "7"; without the macro the display reads "000.7".
REQ-029 SHALL verify: reset is asserted 5 cycles into a conversion -> no commit occurs, outputs return to reset values, and normal operation resumes at the next frame start.
REQ-030 SHALL verify: a run of ≥1000 cycles -> fnd_digit is always one-hot-low or 1111, and tick spacing is exactly 32 cycles.
